// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I/RV64I decode stage.
//   - RISC-V base opcode constants (instr[6:0])
//   - instr_type_e: instruction format code reported on out_type
//   - occ_state_e:  occupancy state of the stage (0, 1 or 2 held entries)
//   - decoded_t:    decoded field bundle. The immediate is held at XLEN_MAX
//                   bits and truncated to XLEN where the bundle is stored.
package decode_pkg;

   localparam int XLEN_MAX = 64;

   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;

   typedef enum logic [2:0] {
      T_NONE = 3'd0,
      T_U    = 3'd1,
      T_J    = 3'd2,
      T_B    = 3'd3,
      T_I    = 3'd4,
      T_S    = 3'd5,
      T_R    = 3'd6
   } instr_type_e;

   typedef enum logic [1:0] {
      OCC_EMPTY = 2'd0,
      OCC_ONE   = 2'd1,
      OCC_TWO   = 2'd2
   } occ_state_e;

   typedef struct packed {
      logic [6:0]          op;
      logic [4:0]          rd;
      logic [4:0]          rs1;
      logic [4:0]          rs2;
      logic [2:0]          funct3;
      logic [6:0]          funct7;
      logic [XLEN_MAX-1:0] imm;
      instr_type_e         itype;
      logic                illegal;
   } decoded_t;

endpackage

// File: rtl/decode_if.sv
// decode_if: fetch-side and consumer-side handshake bundle of decode_stage.
//   in_valid/in_ready/in_instr/in_pc/in_tag     : fetch -> stage
//   out_valid/out_ready/out_*                   : stage -> consumer
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. A producer holding valid must keep its payload stable until that
// edge; valid never depends combinationally on ready in either direction.
// modport slave is the stage's view, modport master the environment's view.
interface decode_if #(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int TAG_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [PC_W-1:0]  in_pc;
   logic [TAG_W-1:0] in_tag;

   logic             out_valid;
   logic             out_ready;
   logic [6:0]       out_op;
   logic [4:0]       out_rd;
   logic [4:0]       out_rs1;
   logic [4:0]       out_rs2;
   logic [2:0]       out_funct3;
   logic [6:0]       out_funct7;
   logic [XLEN-1:0]  out_imm;
   logic [2:0]       out_type;
   logic             out_illegal;
   logic [PC_W-1:0]  out_pc;
   logic [TAG_W-1:0] out_tag;

   modport slave (
      input  in_valid, in_instr, in_pc, in_tag, out_ready,
      output in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_imm, out_type, out_illegal,
             out_pc, out_tag
   );

   modport master (
      output in_valid, in_instr, in_pc, in_tag, out_ready,
      input  in_ready, out_valid, out_op, out_rd, out_rs1, out_rs2,
             out_funct3, out_funct7, out_imm, out_type, out_illegal,
             out_pc, out_tag
   );
endinterface

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I/RV64I field and immediate extraction.
//   instr : raw 32-bit instruction word
//   dec   : decoded bundle; fields not used by the format are 0, immediate is
//           sign-extended to XLEN_MAX. Unknown opcodes give itype T_NONE,
//           illegal=1 and only op populated.
// OP-IMM-32 / OP-32 are recognised only when XLEN == 64.
module decode_comb
   import decode_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0] instr,
   output decoded_t    dec
);

   instr_type_e         itype;
   logic [XLEN_MAX-1:0] imm_u, imm_j, imm_b, imm_i, imm_s;
   logic                shift_imm;

   assign imm_u = {{32{instr[31]}}, instr[31:12], 12'b0};
   assign imm_j = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
   assign imm_b = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign imm_i = {{52{instr[31]}}, instr[31:20]};
   assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};

   // Shift-immediates (funct3 001/101) carry a funct7 in instr[31:25].
   assign shift_imm = ((instr[6:0] == OPC_OP_IMM) ||
                       ((XLEN == 64) && (instr[6:0] == OPC_OP_IMM_32))) &&
                      (instr[13:12] == 2'b01);

   // Every legal opcode ends in 2'b11, so a mismatch on instr[1:0] always
   // falls through to T_NONE.
   always_comb begin
      itype = T_NONE;
      case (instr[6:0])
         OPC_LUI, OPC_AUIPC:                 itype = T_U;
         OPC_JAL:                            itype = T_J;
         OPC_BRANCH:                         itype = T_B;
         OPC_JALR, OPC_LOAD, OPC_OP_IMM,
         OPC_MISC_MEM, OPC_SYSTEM:           itype = T_I;
         OPC_OP_IMM_32:                      itype = (XLEN == 64) ? T_I : T_NONE;
         OPC_STORE:                          itype = T_S;
         OPC_OP:                             itype = T_R;
         OPC_OP_32:                          itype = (XLEN == 64) ? T_R : T_NONE;
         default:                            itype = T_NONE;
      endcase
   end

   always_comb begin
      dec         = '0;
      dec.op      = instr[6:0];
      dec.itype   = itype;
      dec.illegal = (itype == T_NONE);
      case (itype)
         T_U: begin
            dec.rd  = instr[11:7];
            dec.imm = imm_u;
         end
         T_J: begin
            dec.rd  = instr[11:7];
            dec.imm = imm_j;
         end
         T_B: begin
            dec.rs1    = instr[19:15];
            dec.rs2    = instr[24:20];
            dec.funct3 = instr[14:12];
            dec.imm    = imm_b;
         end
         T_I: begin
            dec.rd     = instr[11:7];
            dec.rs1    = instr[19:15];
            dec.funct3 = instr[14:12];
            dec.imm    = imm_i;
            if (shift_imm) dec.funct7 = instr[31:25];
         end
         T_S: begin
            dec.rs1    = instr[19:15];
            dec.rs2    = instr[24:20];
            dec.funct3 = instr[14:12];
            dec.imm    = imm_s;
         end
         T_R: begin
            dec.rd     = instr[11:7];
            dec.rs1    = instr[19:15];
            dec.rs2    = instr[24:20];
            dec.funct3 = instr[14:12];
            dec.funct7 = instr[31:25];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I decode stage with a 2-entry skid
// (output register "main" plus one skid entry) so in_ready is a flop.
//   clk, reset : clock, synchronous active-high reset
//   flush      : drop every held instruction and any same-cycle input
//   bus        : decode_if.slave, fetch-side input and consumer-side output
//   dbg_state  : current occupancy state (EMPTY/ONE/TWO)
// Optional build macro DECODE_PERF_CNT_EN adds perf_decoded / perf_illegal
// (32-bit, wrap, count output transfers; cleared by reset only).
module decode_stage
   import decode_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int PC_W  = 32,
   parameter int TAG_W = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       flush,
   decode_if.slave    bus,
   output occ_state_e dbg_state
`ifdef DECODE_PERF_CNT_EN
   ,
   output logic [31:0] perf_decoded,
   output logic [31:0] perf_illegal
`endif
);

   typedef struct packed {
      logic [6:0]       op;
      logic [4:0]       rd;
      logic [4:0]       rs1;
      logic [4:0]       rs2;
      logic [2:0]       funct3;
      logic [6:0]       funct7;
      logic [XLEN-1:0]  imm;
      instr_type_e      itype;
      logic             illegal;
      logic [PC_W-1:0]  pc;
      logic [TAG_W-1:0] tag;
   } entry_t;

   decoded_t   dec_w;
   entry_t     in_entry, main_q, skid_q;
   occ_state_e state, state_next;
   logic       in_ready_q;
   logic       accept, drain, out_valid;
   logic       load_main_in, load_skid, main_from_skid;

   decode_comb #(.XLEN(XLEN)) u_comb (
      .instr (bus.in_instr),
      .dec   (dec_w)
   );

   // Only the low XLEN bits of the wide immediate are kept.
   generate
      if (XLEN < XLEN_MAX) begin : g_trunc
         logic unused_imm_hi;
         assign unused_imm_hi = ^dec_w.imm[XLEN_MAX-1:XLEN];
      end
   endgenerate

   assign in_entry = '{op: dec_w.op, rd: dec_w.rd, rs1: dec_w.rs1, rs2: dec_w.rs2,
                       funct3: dec_w.funct3, funct7: dec_w.funct7,
                       imm: dec_w.imm[XLEN-1:0], itype: dec_w.itype,
                       illegal: dec_w.illegal, pc: bus.in_pc, tag: bus.in_tag};

   assign out_valid = (state != OCC_EMPTY);
   assign accept    = bus.in_valid & in_ready_q;
   assign drain     = out_valid & bus.out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= OCC_EMPTY;
         in_ready_q <= 1'b1;
      end else begin
         state      <= state_next;
         in_ready_q <= (state_next != OCC_TWO);
      end
   end

   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_skid      = 1'b0;
      main_from_skid = 1'b0;
      if (flush) begin
         state_next = OCC_EMPTY;
      end else begin
         case (state)
            OCC_EMPTY: if (accept) begin
               state_next   = OCC_ONE;
               load_main_in = 1'b1;
            end
            OCC_ONE: begin
               if (accept && drain) begin
                  load_main_in = 1'b1;
               end else if (accept) begin
                  state_next = OCC_TWO;
                  load_skid  = 1'b1;
               end else if (drain) begin
                  state_next = OCC_EMPTY;
               end
            end
            // in_ready is low here, so only a drain can happen.
            OCC_TWO: if (drain) begin
               state_next     = OCC_ONE;
               main_from_skid = 1'b1;
            end
            default: state_next = OCC_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q <= '0;
         skid_q <= '0;
      end else begin
         if (load_main_in)        main_q <= in_entry;
         else if (main_from_skid) main_q <= skid_q;
         if (load_skid)           skid_q <= in_entry;
      end
   end

`ifdef DECODE_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_decoded <= '0;
         perf_illegal <= '0;
      end else if (drain) begin
         perf_decoded <= perf_decoded + 32'd1;
         if (main_q.illegal) perf_illegal <= perf_illegal + 32'd1;
      end
   end
`endif

   assign dbg_state       = state;
   assign bus.in_ready    = in_ready_q;
   assign bus.out_valid   = out_valid;
   assign bus.out_op      = main_q.op;
   assign bus.out_rd      = main_q.rd;
   assign bus.out_rs1     = main_q.rs1;
   assign bus.out_rs2     = main_q.rs2;
   assign bus.out_funct3  = main_q.funct3;
   assign bus.out_funct7  = main_q.funct7;
   assign bus.out_imm     = main_q.imm;
   assign bus.out_type    = main_q.itype;
   assign bus.out_illegal = main_q.illegal;
   assign bus.out_pc      = main_q.pc;
   assign bus.out_tag     = main_q.tag;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage (XLEN=64 build).
// A queue of expected decoded bundles models the stage: at most two held,
// head is what out_* must show. Directed cases first, then random traffic.
module tb_decode_stage;

   localparam int XLEN  = 64;
   localparam int PC_W  = 32;
   localparam int TAG_W = 4;

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic [63:0] imm;
      logic [2:0]  typ;
      logic        ill;
      logic [31:0] pc;
      logic [3:0]  tag;
   } exp_t;

   localparam int EXP_W = $bits(exp_t);

   logic clk;
   logic reset;
   logic flush;
   decode_pkg::occ_state_e dbg_state;
`ifdef DECODE_PERF_CNT_EN
   logic [31:0] perf_decoded, perf_illegal;
`endif

   decode_if #(.XLEN(XLEN), .PC_W(PC_W), .TAG_W(TAG_W)) bus ();

   decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .TAG_W(TAG_W)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .bus          (bus),
      .dbg_state    (dbg_state)
`ifdef DECODE_PERF_CNT_EN
      ,
      .perf_decoded (perf_decoded),
      .perf_illegal (perf_illegal)
`endif
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [31:0] cnt_dec = 0;
   logic [31:0] cnt_ill = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference decoder ----------------
   function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                       input logic [3:0] tag);
      exp_t e;
      int t;
      logic signed [31:0] sw;
      longint s;
      e = '0; e.op = w[6:0]; e.pc = pc; e.tag = tag;
      sw = w; s = 0;
      case (w[6:0])
         7'h37, 7'h17:                      t = 1;
         7'h6f:                             t = 2;
         7'h63:                             t = 3;
         7'h67, 7'h03, 7'h13, 7'h0f, 7'h73: t = 4;
         7'h1b:                             t = (XLEN == 64) ? 4 : 0;
         7'h23:                             t = 5;
         7'h33:                             t = 6;
         7'h3b:                             t = (XLEN == 64) ? 6 : 0;
         default:                           t = 0;
      endcase
      e.typ = 3'(t);
      e.ill = (t == 0);
      if (t == 1 || t == 2 || t == 4 || t == 6) e.rd  = w[11:7];
      if (t >= 3)                               e.rs1 = w[19:15];
      if (t == 3 || t == 5 || t == 6)           e.rs2 = w[24:20];
      if (t >= 3)                               e.f3  = w[14:12];
      if (t == 6 || (t == 4 && (w[6:0] == 7'h13 || w[6:0] == 7'h1b) && w[13:12] == 2'b01))
         e.f7 = w[31:25];
      case (t)
         1: s = longint'(sw >>> 12) * 4096;
         2: s = longint'(sw >>> 31) * 1048576 + longint'(w[19:12]) * 4096 +
                longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
         3: s = longint'(sw >>> 31) * 4096 + longint'(w[7]) * 2048 +
                longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
         4: s = longint'(sw >>> 20);
         5: s = longint'(sw >>> 25) * 32 + longint'(w[11:7]);
         default: s = 0;
      endcase
      e.imm = (XLEN == 64) ? 64'(s) : {32'b0, s[31:0]};
      return e;
   endfunction

   // ---------------- driver tasks ----------------
   // Compare DUT against the model at the falling edge.
   task automatic sync();
      exp_t e;
      @(negedge clk);
      check("in_ready",  bus.in_ready,  exp_q.size() < 2);
      check("out_valid", bus.out_valid, exp_q.size() > 0);
      check("state",     dbg_state,     exp_q.size());
      if (exp_q.size() > 0) begin
         e = exp_t'(exp_q[0]);
         check("op",      bus.out_op,      e.op);
         check("rd",      bus.out_rd,      e.rd);
         check("rs1",     bus.out_rs1,     e.rs1);
         check("rs2",     bus.out_rs2,     e.rs2);
         check("funct3",  bus.out_funct3,  e.f3);
         check("funct7",  bus.out_funct7,  e.f7);
         check("imm",     bus.out_imm,     e.imm);
         check("type",    bus.out_type,    e.typ);
         check("illegal", bus.out_illegal, e.ill);
         check("pc",      bus.out_pc,      e.pc);
         check("tag",     bus.out_tag,     e.tag);
      end
`ifdef DECODE_PERF_CNT_EN
      check("perf_decoded", perf_decoded, cnt_dec);
      check("perf_illegal", perf_illegal, cnt_ill);
`endif
   endtask

   // Drive one cycle of inputs and advance the model across the next edge.
   task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] pc,
                        input logic [3:0] tag, input logic ordy, input logic fl);
      bit   acc, drn;
      exp_t h;
      bus.in_valid  = v;
      bus.in_instr  = w;
      bus.in_pc     = pc;
      bus.in_tag    = tag;
      bus.out_ready = ordy;
      flush         = fl;
      acc = v && (exp_q.size() < 2);
      drn = ordy && (exp_q.size() > 0);
      if (drn) begin
         h = exp_t'(exp_q[0]);
         cnt_dec++;
         if (h.ill) cnt_ill++;
      end
      if (fl) exp_q.delete();
      else begin
         if (drn) void'(exp_q.pop_front());
         if (acc) exp_q.push_back(ref_decode(w, pc, tag));
      end
      @(posedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      exp_q.delete();
      cnt_dec = 0; cnt_ill = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   function automatic logic [31:0] rand_instr();
      logic [6:0] opc[13];
      logic [31:0] w;
      opc = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33,
              7'h0f, 7'h73, 7'h1b, 7'h3b};
      w = $urandom();
      if ($urandom_range(0, 4) != 0) w[6:0] = opc[$urandom_range(0, 12)];
      return w;
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] pd_before;
      reset = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_pc = '0; bus.in_tag = '0;
      bus.out_ready = 1'b0;
      do_reset();

      // Reset values: all data outputs zero.
      sync();
      check("rst_op",   bus.out_op,      0);
      check("rst_imm",  bus.out_imm,     0);
      check("rst_pc",   bus.out_pc,      0);
      check("rst_tag",  bus.out_tag,     0);
      check("rst_type", bus.out_type,    0);
      check("rst_ill",  bus.out_illegal, 0);

      // LUI x5, 0x12345
      drive(1, 32'h123452B7, 32'h100, 4'h1, 1, 0);
      sync();
      check("lui_type", bus.out_type, 1);
      check("lui_rd",   bus.out_rd,   5);
      check("lui_imm",  bus.out_imm,  64'h12345000);
      check("lui_rdy",  bus.in_ready, 1);

      // ADDI x1,x0,-1 then SRAI x5,x2,3 back to back
      drive(1, 32'hFFF00093, 32'h104, 4'h2, 1, 0);
      sync();
      check("addi_type", bus.out_type,   4);
      check("addi_imm",  bus.out_imm,    64'hFFFF_FFFF_FFFF_FFFF);
      check("addi_rs1",  bus.out_rs1,    0);
      check("addi_f7",   bus.out_funct7, 0);
      drive(1, 32'h40315293, 32'h108, 4'h3, 1, 0);
      sync();
      check("srai_f7",   bus.out_funct7,     7'h20);
      check("srai_imm",  bus.out_imm[11:0],  12'h403);
      check("srai_type", bus.out_type,       4);
      drive(0, 0, 0, 0, 1, 0);

      // Backpressure: A, B held; C refused until space frees.
      sync(); drive(1, 32'h00100093, 32'h200, 4'h4, 0, 0);
      sync(); drive(1, 32'h00208133, 32'h204, 4'h5, 0, 0);
      sync();
      check("bp_rdy_lo", bus.in_ready, 0);
      drive(1, 32'h00312023, 32'h208, 4'h6, 0, 0);
      sync();
      check("bp_head_a", bus.out_pc, 32'h200);
      drive(1, 32'h00312023, 32'h208, 4'h6, 1, 0);
      sync();
      check("bp_head_b", bus.out_pc, 32'h204);
      drive(1, 32'h00312023, 32'h208, 4'h6, 1, 0);
      sync();
      check("bp_head_c", bus.out_pc, 32'h208);
      check("bp_c_type", bus.out_type, 5);
      drive(0, 0, 0, 0, 1, 0);
      sync();
      check("bp_empty", bus.out_valid, 0);

      // Illegal encodings still delivered with pc/tag.
      drive(1, 32'h0000007F, 32'h300, 4'hA, 1, 0);
      sync();
      check("ill7f_ill",  bus.out_illegal, 1);
      check("ill7f_type", bus.out_type,    0);
      check("ill7f_pc",   bus.out_pc,      32'h300);
      check("ill7f_tag",  bus.out_tag,     4'hA);
      drive(1, 32'h00000000, 32'h304, 4'h5, 1, 0);
      sync();
      check("ill00_ill",  bus.out_illegal, 1);
      check("ill00_imm",  bus.out_imm,     0);
      check("ill00_tag",  bus.out_tag,     4'h5);
      drive(0, 0, 0, 0, 1, 0);

      // Flush with two held and a same-cycle input.
      sync(); drive(1, 32'h0000006F, 32'h400, 4'h1, 0, 0);
      sync(); drive(1, 32'h00000063, 32'h404, 4'h2, 0, 0);
      sync();
      pd_before = cnt_dec;
      drive(1, 32'h00000013, 32'h408, 4'h3, 0, 1);
      sync();
      check("fl_valid", bus.out_valid, 0);
      check("fl_ready", bus.in_ready,  1);
`ifdef DECODE_PERF_CNT_EN
      check("fl_perf", perf_decoded, pd_before);
`endif
      drive(0, 0, 0, 0, 1, 0);

      // Reset with two held.
      sync(); drive(1, 32'h00000037, 32'h500, 4'h1, 0, 0);
      sync(); drive(1, 32'h00000017, 32'h504, 4'h2, 0, 0);
      do_reset();
      sync();
      check("rs_valid", bus.out_valid, 0);
      drive(0, 0, 0, 0, 1, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         sync();
         drive($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
               4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
               $urandom_range(0, 40) == 0);
      end
      sync();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
